button_conditioner: RTL and testbench

Front-end conditioning stage for the Basys 3 push buttons that drive the LED strip controller's changeMode and send inputs. It synchronizes raw asynchronous button levels, debounces them, and emits a single-cycle press pulse per debounced press. Each channel can optionally auto-repeat while held, so holding the send button re-sends frames at a fixed rate. Outputs feed the mode/send logic directly, replacing raw btnU/btnD.

---
 rtl/button_pkg.sv | 21 ++
 rtl/debounce_channel.sv | 111 +++++++++++
 rtl/button_conditioner.sv | 34 +++
 tb/tb_button_conditioner.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared constants and press-FSM encoding for the push-button conditioning front end.
package button_pkg;

  localparam int DB_CYCLES_100MHZ     = 1_000_000;
  localparam int REPEAT_DELAY_100MHZ  = 50_000_000;
  localparam int REPEAT_PERIOD_100MHZ = 10_000_000;

  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    DELAY    = 2'd1,
    REPEAT   = 2'd2
  } press_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, stability-count debouncer, and a press
// FSM that emits one-cycle pulses on press and, when enabled, on auto-repeat.
module debounce_channel
  import button_pkg::*;
#(
  parameter int DB_CYCLES     = DB_CYCLES_100MHZ,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_100MHZ,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_100MHZ
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic repeat_en,
  output logic level,
  output logic pulse
);

  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [DW-1:0] DB_LAST     = DW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic          sync1;
  logic          s;
  logic          stable;
  logic [DW-1:0] cnt;
  logic [RW-1:0] rcnt;
  press_state_e  state;

  logic db_done;
  logic accept_rise;
  logic accept_fall;

  assign db_done     = (s != stable) && (cnt == DB_LAST);
  assign accept_rise = db_done && s;
  assign accept_fall = db_done && !s;
  assign level       = stable;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1  <= 1'b0;
      s      <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
      if (s == stable) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        stable <= s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // A counter match while pulse is still high holds the count at zero, so even a
  // period of one cycle can never produce back-to-back pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RELEASED;
      rcnt  <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (state != RELEASED && (!stable || accept_fall)) begin
        state <= RELEASED;
        rcnt  <= '0;
      end else begin
        case (state)
          RELEASED: begin
            rcnt <= '0;
            if (accept_rise) begin
              pulse <= 1'b1;
              state <= DELAY;
            end
          end
          DELAY: begin
            if (repeat_en) begin
              if (rcnt == DELAY_LAST) begin
                rcnt <= '0;
                if (!pulse) begin
                  pulse <= 1'b1;
                  state <= REPEAT;
                end
              end else begin
                rcnt <= rcnt + 1'b1;
              end
            end
          end
          REPEAT: begin
            if (rcnt == PERIOD_LAST) begin
              rcnt <= '0;
              if (!pulse) pulse <= 1'b1;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          default: begin
            state <= RELEASED;
            rcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions N raw push buttons into debounced levels and press/auto-repeat pulses;
// each channel is an independent debounce_channel instance.
module button_conditioner
  import button_pkg::*;
#(
  parameter int             N             = 2,
  parameter int             DB_CYCLES     = DB_CYCLES_100MHZ,
  parameter logic [N-1:0]   REPEAT_MASK   = N'(2'b10),
  parameter int             REPEAT_DELAY  = REPEAT_DELAY_100MHZ,
  parameter int             REPEAT_PERIOD = REPEAT_PERIOD_100MHZ
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] btnRaw,
  output logic [N-1:0] btnLevel,
  output logic [N-1:0] btnPulse
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .raw      (btnRaw[i]),
      .repeat_en(REPEAT_MASK[i]),
      .level    (btnLevel[i]),
      .pulse    (btnPulse[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3;
// edge numbers are counted from the first clock edge after a stimulus change.
module tb_button_conditioner;

  logic       clk;
  logic       reset;
  logic [1:0] btnRaw;
  logic [1:0] btnLevel;
  logic [1:0] btnPulse;

  int checks = 0;
  int passes = 0;
  int e      = 0;
  logic [1:0]  pulse_hist [0:127];
  logic [1:0]  level_hist [0:127];
  logic [31:0] exp_q [$];

  button_conditioner #(
    .N            (2),
    .DB_CYCLES    (4),
    .REPEAT_MASK  (2'b10),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btnRaw  (btnRaw),
    .btnLevel(btnLevel),
    .btnPulse(btnPulse)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else passes++;
  endtask

  // one clock edge; outputs sampled 1 ns after it and logged under edge index e
  task automatic step();
    @(posedge clk);
    #1;
    pulse_hist[e] = btnPulse;
    level_hist[e] = btnLevel;
    e++;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // scoreboard: pulses seen on channel ch over edges 0..n-1 against exp_q
  task automatic check_pulses(input string tag, input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      if (pulse_hist[i][ch]) begin
        if (exp_q.size() == 0) check({tag, "_extra"}, i, -1);
        else check({tag, "_edge"}, i, int'(exp_q.pop_front()));
      end
    end
    check({tag, "_missing"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    btnRaw = 2'b00;
    reset  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_level", btnLevel, 0);
    check("reset_pulse", btnPulse, 0);
    reset = 1'b1;
    idle(5);

    // clean press on ch0 (no repeat), then release
    e = 0;
    btnRaw[0] = 1'b1;
    idle(30);
    check("ch0_level_e4", level_hist[4][0], 0);
    check("ch0_level_e5", level_hist[5][0], 1);
    exp_q.push_back(5);
    check_pulses("ch0_press", 0, 30);
    check_pulses("ch0_press_ch1_quiet", 1, 30);
    e = 0;
    btnRaw[0] = 1'b0;
    idle(10);
    check("ch0_rel_level_e4", level_hist[4][0], 1);
    check("ch0_rel_level_e5", level_hist[5][0], 0);
    check_pulses("ch0_release", 0, 10);

    // bounce on ch1, hold into repeat, release landing on a repeat expiry (edge 46)
    e = 0;
    btnRaw[1] = 1'b1;
    idle(3);
    btnRaw[1] = 1'b0;
    step();
    btnRaw[1] = 1'b1;
    idle(37);
    btnRaw[1] = 1'b0;
    idle(20);
    check("ch1_bounce_level_e5", level_hist[5][1], 0);
    check("ch1_bounce_level_e8", level_hist[8][1], 0);
    check("ch1_bounce_level_e9", level_hist[9][1], 1);
    check("ch1_rel_level_e45", level_hist[45][1], 1);
    check("ch1_rel_level_e46", level_hist[46][1], 0);
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q = '{9, 19, 22, 25, 28, 31, 34, 37, 40, 43};
    check_pulses("ch1_hold", 1, 61);

    // fresh press proves the FSM returned to RELEASED with a cleared repeat count
    e = 0;
    btnRaw[1] = 1'b1;
    idle(21);
    exp_q = '{5, 15, 18};
    check_pulses("ch1_repress", 1, 21);
    check("ch1_level_before_reset", level_hist[20][1], 1);
    reset = 1'b0;
    step();
    check("reset_mid_level", level_hist[21], 0);
    check("reset_mid_pulse", pulse_hist[21], 0);
    reset = 1'b1;
    e = 0;
    idle(10);
    check("post_reset_level_e4", level_hist[4][1], 0);
    check("post_reset_level_e5", level_hist[5][1], 1);
    exp_q.push_back(5);
    check_pulses("post_reset", 1, 10);
    btnRaw[1] = 1'b0;
    idle(10);

    // simultaneous presses
    e = 0;
    btnRaw = 2'b11;
    idle(20);
    check("both_pulse_e4", pulse_hist[4], 0);
    check("both_pulse_e5", pulse_hist[5], 3);
    check("both_pulse_e6", pulse_hist[6], 0);
    exp_q.push_back(5);
    check_pulses("both_ch0", 0, 20);
    exp_q = '{5, 15, 18};
    check_pulses("both_ch1", 1, 20);
    btnRaw = 2'b00;
    idle(10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
